bit_unpacker: RTL

- Inverse of the 13-bit coefficient packer in the Power2Round path.
- Reads 52 packed 64-bit words from a word memory and emits 256 13-bit coefficients, one per cycle, to a coefficient memory.
- Used to unpack stored t0 polynomials before further processing.

---
 rtl/power2round_pkg.sv | 39 +++
 rtl/bit_unpacker_if.sv | 25 ++
 rtl/bit_unpack_buffer.sv | 48 ++++
 rtl/bit_unpacker.sv | 104 ++++++++++
 4 files changed

// File: rtl/power2round_pkg.sv
// Shared constants, state encoding and output mapping for the Power2Round coefficient path.
// Build macro BIT_UNPACKER_T0_CENTER_EN selects centered 14-bit signed t0 coefficients.
package power2round_pkg;

    localparam int COEF_W     = 13;
    localparam int WORD_W     = 64;
    localparam int N_COEF     = 256;
    localparam int N_WORD     = 52;
    localparam int IN_ADDR_W  = 6;
    localparam int OUT_ADDR_W = 8;
    localparam int BUF_W      = WORD_W + COEF_W - 1;
    localparam int FILL_W     = 7;

`ifdef BIT_UNPACKER_T0_CENTER_EN
    localparam int OUT_W = COEF_W + 1;
`else
    localparam int OUT_W = COEF_W;
`endif

    localparam logic [FILL_W-1:0] FILL_COEF = FILL_W'(COEF_W);
    localparam logic [FILL_W-1:0] FILL_WORD = FILL_W'(WORD_W);
    // A read issued at this level lands after one more emit, so the buffer never overflows.
    localparam logic [FILL_W-1:0] RD_THRESH = FILL_W'(2 * COEF_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        PROCESS,
        DONE
    } state_e;

    function automatic logic [OUT_W-1:0] map_coef(input logic [COEF_W-1:0] raw);
`ifdef BIT_UNPACKER_T0_CENTER_EN
        return 14'd4096 - {1'b0, raw};
`else
        return raw;
`endif
    endfunction

endpackage

// File: rtl/bit_unpacker_if.sv
// Word-memory read port and coefficient-memory write port of the bit unpacker.
// The master side is the unpacker; the slave side is the memories and control.
interface bit_unpacker_if;
    import power2round_pkg::*;

    logic                  start;
    logic [WORD_W-1:0]     in;
    logic                  in_en;
    logic [IN_ADDR_W-1:0]  in_addr;
    logic [OUT_W-1:0]      out;
    logic                  out_en;
    logic [OUT_ADDR_W-1:0] out_addr;
    logic                  done;

    modport master (
        input  start, in,
        output in_en, in_addr, out, out_en, out_addr, done
    );

    modport slave (
        output start, in,
        input  in_en, in_addr, out, out_en, out_addr, done
    );

endinterface

// File: rtl/bit_unpack_buffer.sv
// LSB-first bit buffer: drops one 13-bit coefficient per cycle when available and
// appends an arriving 64-bit word directly above the remaining bits.
module bit_unpack_buffer
    import power2round_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              word_valid_i,
    input  logic [WORD_W-1:0] word_i,
    output logic              emit_o,
    output logic [COEF_W-1:0] coef_o,
    output logic [FILL_W-1:0] fill_next_o
);

    logic [BUF_W-1:0]  buf_q, buf_d, buf_shifted;
    logic [FILL_W-1:0] fill_q, fill_d;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        emit_o      = (fill_q >= FILL_COEF);
        coef_o      = buf_q[COEF_W-1:0];
        buf_shifted = emit_o ? (buf_q >> COEF_W) : buf_q;
        fill_next_o = emit_o ? (fill_q - FILL_COEF) : fill_q;
        buf_d       = buf_shifted;
        fill_d      = fill_next_o;
        if (clear_i) begin
            buf_d  = '0;
            fill_d = '0;
        end else if (word_valid_i) begin
            buf_d  = buf_shifted | (BUF_W'(word_i) << fill_next_o);
            fill_d = fill_next_o + FILL_WORD;
        end
    end

    // NOTE: the buffer data is reset as well as the fill count: appends OR into the bits above fill, which must start at zero.
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/bit_unpacker.sv
// Unpacks 52 LSB-first packed 64-bit words into 256 13-bit coefficients, one per cycle.
// Build macro BIT_UNPACKER_T0_CENTER_EN emits 4096 - raw as 14-bit two's complement instead.
module bit_unpacker
    import power2round_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    bit_unpacker_if.master bus
);

    state_e                state_q, state_d;
    logic [IN_ADDR_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [OUT_ADDR_W-1:0] coef_cnt_q, coef_cnt_d;
    logic                  out_en_q, out_en_d;
    logic [OUT_ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [OUT_W-1:0]      out_q, out_d;

    logic                  processing;
    logic                  in_en;
    logic                  done;
    logic                  last_write;
    logic                  emit;
    logic [COEF_W-1:0]     raw_coef;
    logic [FILL_W-1:0]     fill_next;

    bit_unpack_buffer u_buffer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (!processing),
        .word_valid_i (rd_pend_q),
        .word_i       (bus.in),
        .emit_o       (emit),
        .coef_o       (raw_coef),
        .fill_next_o  (fill_next)
    );

    assign processing = (state_q == PROCESS);
    assign last_write = out_en_q && (out_addr_q == OUT_ADDR_W'(N_COEF - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = PROCESS;
            PROCESS: if (last_write) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One read in flight at a time, issued only when the word will fit after the next emit.
    always_comb begin
        in_en = processing && !rd_pend_q && (rd_cnt_q < IN_ADDR_W'(N_WORD))
                && (fill_next <= RD_THRESH);
        done  = (state_q == DONE);
    end

    always_comb begin
        rd_pend_d  = in_en;
        rd_cnt_d   = processing ? (rd_cnt_q + IN_ADDR_W'(in_en)) : '0;
        coef_cnt_d = processing ? (coef_cnt_q + OUT_ADDR_W'(emit)) : '0;
        out_en_d   = processing && emit;
        out_addr_d = out_addr_q;
        out_d      = out_q;
        if (processing && emit) begin
            out_addr_d = coef_cnt_q;
            out_d      = map_coef(raw_coef);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q   <= '0;
            rd_pend_q  <= 1'b0;
            coef_cnt_q <= '0;
            out_en_q   <= 1'b0;
            out_addr_q <= '0;
            out_q      <= '0;
        end else begin
            rd_cnt_q   <= rd_cnt_d;
            rd_pend_q  <= rd_pend_d;
            coef_cnt_q <= coef_cnt_d;
            out_en_q   <= out_en_d;
            out_addr_q <= out_addr_d;
            out_q      <= out_d;
        end
    end

    assign bus.in_en    = in_en;
    assign bus.in_addr  = rd_cnt_q;
    assign bus.out      = out_q;
    assign bus.out_en   = out_en_q;
    assign bus.out_addr = out_addr_q;
    assign bus.done     = done;

endmodule
